// File: rtl/fc_pkg.sv
// fc_pkg: FSM state type, accumulator/pass sizing and saturation helpers shared by fc_layer_tm
package fc_pkg;
  typedef enum logic [1:0] {eLOAD, eMAC, eDRAIN, eDONE} fc_state_e;
  function automatic int fc_passes(input int lh, input int nl);
    return (lh + nl - 1) / nl;
  endfunction
  function automatic int fc_acc_width(input int ws, input int ns, input int plh);
    int g = $clog2(plh + 1) + 1;
    return (2 * ws - ns > ws) ? 2 * ws - ns + g : ws + g;
  endfunction
  function automatic logic signed [63:0] fc_sat(input logic signed [63:0] v, input int ws);
    logic signed [63:0] hi = (64'sd1 <<< (ws - 1)) - 64'sd1;
    logic signed [63:0] lo = -(64'sd1 <<< (ws - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one MAC lane (Q-format multiply-accumulate, bias add, saturate, clear; ReLU when FC_LAYER_RELU_EN)
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int N_SIZE    = 8,
  parameter int ACC_WIDTH = 28
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        add_en,
  input  logic                        bias_en,
  input  logic                        clear,
  input  logic signed [WORD_SIZE-1:0] x,
  input  logic signed [WORD_SIZE-1:0] w,
  output logic        [WORD_SIZE-1:0] y
);
  logic signed [2*WORD_SIZE-1:0] prod;
  logic signed [ACC_WIDTH-1:0] acc_q, addend, acc_d;
  always_comb begin
    prod = x * w;
    addend = bias_en ? ACC_WIDTH'(w) : ACC_WIDTH'(prod >>> N_SIZE);
    acc_d = acc_q + (add_en ? addend : ACC_WIDTH'(0));
`ifdef FC_LAYER_RELU_EN
    y = acc_d[ACC_WIDTH-1] ? '0 : WORD_SIZE'(fc_sat(64'(acc_d), WORD_SIZE));
`else
    y = WORD_SIZE'(fc_sat(64'(acc_d), WORD_SIZE));
`endif
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) acc_q <= '0;
    else acc_q <= clear ? '0 : acc_d;
endmodule

// File: rtl/fc_layer_tm.sv
// fc_layer_tm: time-multiplexed fully-connected layer over N_LANES MAC lanes (FC_LAYER_RELU_EN adds ReLU)
module fc_layer_tm
  import fc_pkg::*;
#(
  parameter int WORD_SIZE             = 16,
  parameter int N_SIZE                = 8,
  parameter int LAYER_HEIGHT          = 8,
  parameter int PREVIOUS_LAYER_HEIGHT = 4,
  parameter int N_LANES               = 2,
  localparam int PASSES = fc_passes(LAYER_HEIGHT, N_LANES),
  localparam int AW     = $clog2(PASSES * (PREVIOUS_LAYER_HEIGHT + 1))
) (
  input  logic                                    clk_i,
  input  logic                                    reset_ni,
  input  logic [WORD_SIZE-1:0]                    data_i,
  input  logic                                    empty_i,
  output logic                                    ren_o,
  output logic [AW-1:0]                           weight_addr_o,
  input  logic [N_LANES-1:0][WORD_SIZE-1:0]       weight_i,
  output logic                                    valid_o,
  input  logic                                    yumi_i,
  output logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]  data_o
);
  localparam int PLH   = PREVIOUS_LAYER_HEIGHT;
  localparam int KW    = $clog2(PLH + 1);
  localparam int PW    = PASSES > 1 ? $clog2(PASSES) : 1;
  localparam int LW    = PLH > 1 ? $clog2(PLH) : 1;
  localparam int BW    = PLH * WORD_SIZE;
  localparam int ACC_W = fc_acc_width(WORD_SIZE, N_SIZE, PLH);
  fc_state_e state_q, state_d;
  logic [PW-1:0] p_q;
  logic [KW-1:0] k_q;
  logic [LW-1:0] ld_q;
  logic [BW-1:0] buf_q;
  logic [WORD_SIZE-1:0] x_q;
  logic add_q, bias_q, pop, ld_last, k_last, p_last, drain;
  logic [WORD_SIZE-1:0] y [N_LANES];
  always_comb begin
    pop = state_q == eLOAD && !empty_i && reset_ni;
    ld_last = ld_q == LW'(PLH - 1);
    k_last = k_q == KW'(PLH);
    p_last = p_q == PW'(PASSES - 1);
    drain = state_q == eDRAIN;
    ren_o = pop;
    valid_o = state_q == eDONE;
    weight_addr_o = AW'(int'(p_q) * (PLH + 1) + int'(k_q));
    state_d = state_q;
    case (state_q)
      eLOAD:   state_d = pop && ld_last ? eMAC : eLOAD;
      eMAC:    state_d = k_last ? eDRAIN : eMAC;
      eDRAIN:  state_d = p_last ? eDONE : eMAC;
      default: state_d = yumi_i ? eLOAD : eDONE;
    endcase
  end
  // The input buffer is a shift register: loads shift in at the top, and each
  // operand fetch rotates it by one word, so after PLH fetches it is back in order.
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= eLOAD;
      p_q <= '0;
      k_q <= '0;
      ld_q <= '0;
      buf_q <= '0;
      x_q <= '0;
      add_q <= 1'b0;
      bias_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        ld_q <= ld_last ? '0 : ld_q + 1'b1;
        buf_q <= BW'({data_i, buf_q} >> WORD_SIZE);
      end
      if (state_q == eMAC) begin
        k_q <= k_last ? '0 : k_q + 1'b1;
        x_q <= buf_q[WORD_SIZE-1:0];
        if (!k_last) buf_q <= BW'({buf_q[WORD_SIZE-1:0], buf_q} >> WORD_SIZE);
      end
      if (drain) p_q <= p_last ? '0 : p_q + 1'b1;
      add_q <= state_q == eMAC;
      bias_q <= state_q == eMAC && k_last;
    end
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    fc_mac_lane #(
      .WORD_SIZE(WORD_SIZE),
      .N_SIZE(N_SIZE),
      .ACC_WIDTH(ACC_W)
    ) u_lane (
      .clk_i(clk_i),
      .reset_ni(reset_ni),
      .add_en(add_q),
      .bias_en(bias_q),
      .clear(drain),
      .x(x_q),
      .w(weight_i[l]),
      .y(y[l])
    );
  end
  // Each neuron has a fixed pass and lane, so lanes past LAYER_HEIGHT simply have no register.
  for (genvar n = 0; n < LAYER_HEIGHT; n++) begin : g_out
    logic [WORD_SIZE-1:0] q;
    always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) q <= '0;
      else if (drain && p_q == PW'(n / N_LANES)) q <= y[n % N_LANES];
    assign data_o[n] = q;
  end
endmodule

// File: tb/tb_fc_layer_tm.sv
// tb_fc_layer_tm: table-driven and randomized self-checking bench for fc_layer_tm
module tb_fc_layer_tm;
  localparam int WS = 16, NS = 8, LH = 3, PLH = 4, NL = 2;
  typedef struct {
    logic [WS-1:0] x;
    logic [WS-1:0] w;
    logic [WS-1:0] b;
    int            stall;
    logic [WS-1:0] e;
  } vec_t;
  logic clk = 1'b0, reset_ni = 1'b0;
  logic [WS-1:0] data_i = '0;
  logic empty_i = 1'b1, ren_o, valid_o, yumi_i = 1'b0;
  logic [3:0] weight_addr_o;
  logic [NL-1:0][WS-1:0] weight_i;
  logic [LH-1:0][WS-1:0] data_o;
  fc_layer_tm #(
    .WORD_SIZE(WS),
    .N_SIZE(NS),
    .LAYER_HEIGHT(LH),
    .PREVIOUS_LAYER_HEIGHT(PLH),
    .N_LANES(NL)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .data_i(data_i),
    .empty_i(empty_i),
    .ren_o(ren_o),
    .weight_addr_o(weight_addr_o),
    .weight_i(weight_i),
    .valid_o(valid_o),
    .yumi_i(yumi_i),
    .data_o(data_o)
  );
  always #5 clk = ~clk;
  logic [WS-1:0] mem [16][NL];
  always @(posedge clk) for (int l = 0; l < NL; l++) weight_i[l] <= mem[weight_addr_o][l];
  int total = 0, bad = 0, pops = 0, stall_mode = 0, ncyc = 0, hold_cycles = 0;
  logic [WS-1:0] fifo[$];
  logic signed [WS-1:0] cur_x [PLH];
  logic [WS-1:0] cur_e [LH];
  logic [WS-1:0] last_exp [LH];
  vec_t tbl [7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    bit fire;
    empty_i = fifo.size() == 0 || (stall_mode == 1 && ncyc[0]) || (stall_mode == 2 && $urandom_range(0, 1) == 1);
    data_i = fifo.size() != 0 ? fifo[0] : '0;
    #1;
    fire = ren_o && !empty_i;
    @(posedge clk);
    if (fire) begin
      void'(fifo.pop_front());
      pops++;
    end
    ncyc++;
    @(negedge clk);
  endtask
  function automatic logic [WS-1:0] model(input int n);
    int p = n / NL;
    int l = n % NL;
    longint s = longint'($signed(mem[p*(PLH+1)+PLH][l]));
    for (int k = 0; k < PLH; k++)
      s += (longint'(cur_x[k]) * longint'($signed(mem[p*(PLH+1)+k][l]))) >>> NS;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef FC_LAYER_RELU_EN
    if (s < 0) s = 0;
`endif
    return WS'(s);
  endfunction
  function automatic logic [WS-1:0] act_of(input logic [WS-1:0] e);
`ifdef FC_LAYER_RELU_EN
    return e[WS-1] ? '0 : e;
`else
    return e;
`endif
  endfunction
  function automatic logic [WS-1:0] rnd();
    logic signed [WS-1:0] v = WS'($urandom);
    return v >>> $urandom_range(0, 9);
  endfunction
  task automatic load_table(input int i);
    for (int k = 0; k < PLH; k++) cur_x[k] = tbl[i].x;
    for (int a = 0; a < 16; a++)
      for (int l = 0; l < NL; l++) mem[a][l] = (a % (PLH + 1) == PLH) ? tbl[i].b : tbl[i].w;
    for (int n = 0; n < LH; n++) cur_e[n] = act_of(tbl[i].e);
    stall_mode = tbl[i].stall;
  endtask
  task automatic run_vec(input string nm);
    int guard = 0;
    int lat = 0;
    pops = 0;
    fifo.delete();
    for (int k = 0; k < PLH; k++) fifo.push_back(cur_x[k]);
    fifo.push_back(16'h5A5A);
    while (pops < PLH && guard < 300) begin
      cyc();
      guard++;
    end
    chk({nm, "/load_pops"}, pops, PLH);
    while (!valid_o && lat < 100) begin
      cyc();
      lat++;
      if (lat == 3)
        for (int n = 0; n < LH; n++) chk($sformatf("%s/retain%0d", nm, n), data_o[n], last_exp[n]);
    end
    chk({nm, "/latency"}, lat, 12);
    chk({nm, "/no_extra_pop"}, pops, PLH);
    for (int n = 0; n < LH; n++) chk($sformatf("%s/out%0d", nm, n), data_o[n], cur_e[n]);
    chk({nm, "/ren_done"}, ren_o, 0);
    for (int i = 0; i < hold_cycles; i++) begin
      cyc();
      chk($sformatf("%s/hold_valid%0d", nm, i), valid_o, 1);
      chk($sformatf("%s/hold_ren%0d", nm, i), ren_o, 0);
      for (int n = 0; n < LH; n++) chk($sformatf("%s/hold_out%0d_%0d", nm, i, n), data_o[n], cur_e[n]);
    end
    last_exp = cur_e;
    fifo.delete();
    yumi_i = 1'b1;
    cyc();
    yumi_i = 1'b0;
    chk({nm, "/yumi_to_load"}, valid_o, 0);
  endtask
  initial begin
    tbl[0] = '{16'h0100, 16'h0080, 16'h0000, 0, 16'h0200};
    tbl[1] = '{16'h0100, 16'h0080, 16'h0000, 1, 16'h0200};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 0, 16'h7FFF};
    tbl[3] = '{16'h7FFF, 16'h8001, 16'h0000, 0, 16'h8000};
    tbl[4] = '{16'h0100, 16'h0100, 16'h0010, 2, 16'h0410};
    tbl[5] = '{16'hFF00, 16'h0080, 16'h0000, 0, 16'hFE00};
    tbl[6] = '{16'h0000, 16'h1234, 16'h7000, 0, 16'h7000};
    for (int a = 0; a < 16; a++)
      for (int l = 0; l < NL; l++) mem[a][l] = '0;
    for (int n = 0; n < LH; n++) last_exp[n] = '0;
    empty_i = 1'b0;
    data_i = 16'h0001;
    repeat (2) @(negedge clk);
    chk("reset/ren", ren_o, 0);
    chk("reset/valid", valid_o, 0);
    for (int n = 0; n < LH; n++) chk($sformatf("reset/out%0d", n), data_o[n], 0);
    empty_i = 1'b1;
    reset_ni = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load_table(i);
      hold_cycles = i == 0 ? 10 : 0;
      run_vec($sformatf("tbl%0d", i));
    end
    hold_cycles = 0;
    load_table(0);
    pops = 0;
    fifo.delete();
    for (int k = 0; k < PLH; k++) fifo.push_back(cur_x[k]);
    for (int g = 0; g < 300 && pops < PLH; g++) cyc();
    chk("midrst/load_pops", pops, PLH);
    repeat (8) cyc();
    #2 reset_ni = 1'b0;
    empty_i = 1'b0;
    #1;
    chk("midrst/valid", valid_o, 0);
    chk("midrst/ren", ren_o, 0);
    for (int n = 0; n < LH; n++) chk($sformatf("midrst/out%0d", n), data_o[n], 0);
    fifo.delete();
    empty_i = 1'b1;
    @(negedge clk);
    reset_ni = 1'b1;
    for (int n = 0; n < LH; n++) last_exp[n] = '0;
    run_vec("after_rst");
    for (int i = 0; i < 10; i++) begin
      for (int a = 0; a < 16; a++)
        for (int l = 0; l < NL; l++) mem[a][l] = rnd();
      for (int k = 0; k < PLH; k++) cur_x[k] = rnd();
      stall_mode = $urandom_range(0, 2);
      for (int n = 0; n < LH; n++) cur_e[n] = model(n);
      run_vec($sformatf("rand%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
